// File: rtl/voice_sequencer.sv
// Note sequencer: plays 32-bit note words from an on-chip table and drives a voice's
// pitch_increment / voice_select / gate, timing each gate phase in ticks of TICKDIV clocks.
module voice_sequencer #(
    parameter int NOTES   = 16,
    parameter int ADDRW   = 4,
    parameter int TICKDIV = 480
) (
    input  logic             sample_clock,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [ADDRW-1:0] wr_addr,
    input  logic [31:0]      wr_data,
    input  logic             start,
    input  logic             stop,
    input  logic             loop,
    output logic             busy,
    output logic [ADDRW-1:0] note_index,
    output logic             note_strobe,
    output logic [15:0]      pitch_increment,
    output logic [3:0]       voice_select,
    output logic             gate
);

    localparam int PW = $clog2(TICKDIV);

    typedef enum logic [2:0] {IDLE, FETCH, LOAD, ON, OFF} state_t;

    state_t           state, next_state;
    logic [31:0]      table_mem [NOTES];
    logic [31:0]      rd_word_p1;
    logic [ADDRW-1:0] idx;
    logic             wrapped;
    logic [ADDRW:0]   idx_next;
    logic [5:0]       on_ticks, off_ticks, phase_len, tick_cnt;
    logic [PW-1:0]    presc;
    logic             tick, phase_done, end_song;
    logic             play_start, restart, advance, load_note, clr_phase;

    // Table stage: read-before-write falls out of both ports sampling the old array
    always_ff @(posedge sample_clock) begin
        if (wr_en) table_mem[wr_addr] <= wr_data;
        rd_word_p1 <= table_mem[idx];
    end

    assign idx_next   = {1'b0, idx} + (ADDRW+1)'(1);
    assign tick       = (presc == PW'(TICKDIV - 1));
    assign phase_len  = (state == ON) ? on_ticks : off_ticks;
    assign phase_done = tick && (tick_cnt == phase_len - 6'd1);
    assign end_song   = (rd_word_p1 == 32'h0) || wrapped;

    always_comb begin
        next_state = state;
        play_start = 1'b0;
        restart    = 1'b0;
        advance    = 1'b0;
        load_note  = 1'b0;
        clr_phase  = 1'b0;
        case (state)
            IDLE:  if (start) begin next_state = FETCH; play_start = 1'b1; end
            FETCH: next_state = LOAD;
            LOAD: begin
                if (end_song) begin
                    // A wrapped index reads as 0 but is a full song, so it may still loop
                    if (loop && (wrapped || idx != '0)) begin
                        next_state = FETCH;
                        restart    = 1'b1;
                    end else begin
                        next_state = IDLE;
                    end
                end else begin
                    load_note = 1'b1;
                    if (rd_word_p1[25:20] != 6'd0) begin
                        next_state = ON;
                        clr_phase  = 1'b1;
                    end else if (rd_word_p1[31:26] != 6'd0) begin
                        next_state = OFF;
                        clr_phase  = 1'b1;
                    end else begin
                        next_state = FETCH;
                        advance    = 1'b1;
                    end
                end
            end
            ON: begin
                if (phase_done) begin
                    if (off_ticks != 6'd0) begin
                        next_state = OFF;
                        clr_phase  = 1'b1;
                    end else begin
                        next_state = FETCH;
                        advance    = 1'b1;
                    end
                end
            end
            OFF: if (phase_done) begin next_state = FETCH; advance = 1'b1; end
            default: next_state = IDLE;
        endcase
        if (stop) begin
            next_state = IDLE;
            play_start = 1'b0;
            restart    = 1'b0;
            advance    = 1'b0;
            load_note  = 1'b0;
            clr_phase  = 1'b0;
        end
    end

    assign busy        = (state != IDLE);
    assign note_strobe = load_note;

    // Control/output register stage
    always_ff @(posedge sample_clock) begin
        if (rst) begin
            state           <= IDLE;
            idx             <= '0;
            wrapped         <= 1'b0;
            presc           <= '0;
            tick_cnt        <= '0;
            on_ticks        <= '0;
            off_ticks       <= '0;
            gate            <= 1'b0;
            pitch_increment <= '0;
            voice_select    <= '0;
            note_index      <= '0;
        end else begin
            state <= next_state;
            gate  <= (next_state == ON);
            if (play_start || restart) begin
                idx     <= '0;
                wrapped <= 1'b0;
            end else if (advance) begin
                {wrapped, idx} <= idx_next;
            end
            if (load_note) begin
                pitch_increment <= rd_word_p1[15:0];
                voice_select    <= rd_word_p1[19:16];
                on_ticks        <= rd_word_p1[25:20];
                off_ticks       <= rd_word_p1[31:26];
                note_index      <= idx;
            end
            if (clr_phase || (state != ON && state != OFF)) begin
                presc    <= '0;
                tick_cnt <= '0;
            end else if (tick) begin
                presc    <= '0;
                tick_cnt <= tick_cnt + 6'd1;
            end else begin
                presc <= presc + PW'(1);
            end
        end
    end

endmodule

// File: tb/tb_voice_sequencer.sv
// Directed bench for voice_sequencer (TICKDIV=4): scoreboard of expected notes checked
// on every note_strobe, plus per-cycle gate/strobe traces of each playback.
module tb_voice_sequencer;

    logic        clk = 1'b0;
    logic        rst, wr_en, start, stop, loop;
    logic [3:0]  wr_addr;
    logic [31:0] wr_data;
    logic        busy, note_strobe, gate;
    logic [3:0]  note_index, voice_select;
    logic [15:0] pitch_increment;

    typedef struct packed {
        logic [3:0]  idx;
        logic [15:0] pitch;
        logic [3:0]  voice;
    } note_t;

    note_t exp_q[$];
    note_t pend_note;
    bit    pend = 1'b0;
    int    n_cmp = 0;
    int    n_err = 0;
    bit    gate_tr[512];
    bit    stb_tr[512];
    int    n;

    voice_sequencer #(.NOTES(16), .ADDRW(4), .TICKDIV(4)) dut (
        .sample_clock(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .stop(stop), .loop(loop), .busy(busy), .note_index(note_index),
        .note_strobe(note_strobe), .pitch_increment(pitch_increment),
        .voice_select(voice_select), .gate(gate)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: observed no finish, required finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: pop on each strobe, compare the registered note fields one cycle later
    always @(negedge clk) begin
        if (pend) begin
            chk("sb_pitch", pitch_increment, pend_note.pitch);
            chk("sb_voice", voice_select, pend_note.voice);
            chk("sb_index", note_index, pend_note.idx);
            pend = 1'b0;
        end
        if (note_strobe === 1'b1) begin
            chk("sb_strobe_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                pend_note = exp_q.pop_front();
                pend = 1'b1;
            end
        end
    end

    function automatic int count_gate(input int len);
        int c = 0;
        for (int i = 0; i < len; i++) if (gate_tr[i]) c++;
        return c;
    endfunction

    function automatic int count_stb(input int len);
        int c = 0;
        for (int i = 0; i < len; i++) if (stb_tr[i]) c++;
        return c;
    endfunction

    function automatic int first_gate(input int len);
        for (int i = 0; i < len; i++) if (gate_tr[i]) return i;
        return -1;
    endfunction

    function automatic int last_gate(input int len);
        int l = -1;
        for (int i = 0; i < len; i++) if (gate_tr[i]) l = i;
        return l;
    endfunction

    task automatic wr(input int a, input logic [31:0] d);
        @(negedge clk);
        wr_en = 1'b1;
        wr_addr = 4'(a);
        wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic push(input int i, input int p, input int v);
        note_t e;
        e.idx = 4'(i);
        e.pitch = 16'(p);
        e.voice = 4'(v);
        exp_q.push_back(e);
    endtask

    // Pulse start, then record one trace entry per busy cycle (bounded by max)
    task automatic play(input int max, input bit endless, output int len);
        len = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (busy === 1'b1 && len < max) begin
            gate_tr[len] = gate;
            stb_tr[len] = note_strobe;
            len++;
            if (len < max) @(negedge clk);
        end
        if (!endless && len >= max) chk("play_timeout_busy", busy, 0);
    endtask

    task automatic stop_pulse();
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        start = 1'b0; stop = 1'b0; loop = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_gate", gate, 0);
        chk("rst_strobe", note_strobe, 0);
        chk("rst_pitch", pitch_increment, 0);
        chk("rst_voice", voice_select, 0);
        chk("rst_index", note_index, 0);
        rst = 1'b0;

        // 1: single note on=3 off=2 then end marker
        wr(0, {6'd2, 6'd3, 4'd1, 16'h0100});
        wr(1, 32'h0);
        push(0, 16'h0100, 1);
        play(200, 0, n);
        chk("t1_busy_len", n, 24);
        chk("t1_strobe_pos", stb_tr[1], 1);
        chk("t1_strobe_cnt", count_stb(n), 1);
        chk("t1_gate_cnt", count_gate(n), 12);
        chk("t1_gate_first", first_gate(n), 2);
        chk("t1_gate_last", last_gate(n), 13);
        chk("t1_end_gate", gate, 0);

        // 2: same table looping, stopped during the fourth ON phase
        loop = 1'b1;
        repeat (4) push(0, 16'h0100, 1);
        play(76, 1, n);
        chk("t2_len", n, 76);
        chk("t2_strobe_cnt", count_stb(n), 4);
        chk("t2_strobe_25", stb_tr[25], 1);
        chk("t2_strobe_49", stb_tr[49], 1);
        chk("t2_strobe_73", stb_tr[73], 1);
        chk("t2_gate_cnt", count_gate(n), 38);
        chk("t2_gate_26", gate_tr[26], 1);
        stop_pulse();
        chk("t2_stop_busy", busy, 0);
        chk("t2_stop_gate", gate, 0);
        chk("t2_stop_pitch", pitch_increment, 16'h0100);
        chk("t2_stop_index", note_index, 0);
        loop = 1'b0;
        chk("t2_sb_empty", exp_q.size(), 0);

        // 3: full table, on=1 off=0, wrap ends the song
        for (int k = 0; k < 16; k++) begin
            wr(k, {6'd0, 6'd1, 4'(k), 16'(k)});
            push(k, k, k);
        end
        play(300, 0, n);
        chk("t3_busy_len", n, 98);
        chk("t3_strobe_cnt", count_stb(n), 16);
        chk("t3_gate_cnt", count_gate(n), 64);
        chk("t3_gate_5", gate_tr[5], 1);
        chk("t3_dip_6", gate_tr[6], 0);
        chk("t3_dip_7", gate_tr[7], 0);
        chk("t3_gate_8", gate_tr[8], 1);
        chk("t3_pitch_last", pitch_increment, 15);
        chk("t3_index_last", note_index, 15);
        chk("t3_sb_empty", exp_q.size(), 0);

        // 4: stop during note 1's ON phase, then replay from index 0
        push(0, 0, 0);
        push(1, 1, 1);
        play(10, 1, n);
        chk("t4_len", n, 10);
        chk("t4_gate_on", gate_tr[9], 1);
        stop_pulse();
        chk("t4_stop_busy", busy, 0);
        chk("t4_stop_gate", gate, 0);
        chk("t4_hold_pitch", pitch_increment, 1);
        chk("t4_hold_voice", voice_select, 1);
        push(0, 0, 0);
        play(3, 1, n);
        chk("t4_replay_strobe", stb_tr[1], 1);
        chk("t4_replay_gate", gate_tr[2], 1);
        stop_pulse();
        chk("t4_sb_empty", exp_q.size(), 0);

        // 5: empty table with loop
        for (int k = 0; k < 16; k++) wr(k, 32'h0);
        loop = 1'b1;
        play(50, 0, n);
        chk("t5_busy_len", n, 2);
        chk("t5_strobe_cnt", count_stb(n), 0);
        loop = 1'b0;

        // 6: zero-length note followed by a normal note
        wr(0, 32'h0002_0200);
        wr(1, 32'h0423_0300);
        wr(2, 32'h0);
        push(0, 16'h0200, 2);
        push(1, 16'h0300, 3);
        play(200, 0, n);
        chk("t6_busy_len", n, 18);
        chk("t6_strobe_cnt", count_stb(n), 2);
        chk("t6_strobe_1", stb_tr[1], 1);
        chk("t6_strobe_3", stb_tr[3], 1);
        chk("t6_gate_first", first_gate(n), 4);
        chk("t6_gate_cnt", count_gate(n), 8);
        chk("t6_gate_last", last_gate(n), 11);

        // start and stop together stays idle
        @(negedge clk);
        start = 1'b1;
        stop = 1'b1;
        @(negedge clk);
        start = 1'b0;
        stop = 1'b0;
        chk("ss_busy", busy, 0);
        @(negedge clk);
        chk("ss_busy_later", busy, 0);

        // reset mid-playback clears outputs but keeps the table
        push(0, 16'h0200, 2);
        push(1, 16'h0300, 3);
        play(6, 1, n);
        chk("rm_len", n, 6);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rm_busy", busy, 0);
        chk("rm_gate", gate, 0);
        chk("rm_pitch", pitch_increment, 0);
        chk("rm_voice", voice_select, 0);
        chk("rm_index", note_index, 0);
        push(0, 16'h0200, 2);
        push(1, 16'h0300, 3);
        play(200, 0, n);
        chk("rm_replay_len", n, 18);
        chk("rm_replay_pitch", pitch_increment, 16'h0300);
        @(negedge clk);
        chk("final_sb_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/voice_sequencer.md
Name: voice_sequencer

Overview:
Note sequencer that drives a voice's control inputs (pitch_increment, voice_select, gate) from a small on-chip note table. The CPU writes note words into the table. The sequencer then plays them in order, timing each gate-on and gate-off phase in ticks derived from sample_clock. It sits upstream of one voice instance and its outputs connect directly to that voice's control ports.

Parameters:
NOTES, 16, note table depth (power of two)
ADDRW, 4, table address width, log2(NOTES)
TICKDIV, 480, sample_clock cycles per tick (>=2)

Ports:
sample_clock  in  1  clock, also the audio sample clock
rst  in  1  synchronous, active-high reset
wr_en  in  1  table write strobe
wr_addr  in  ADDRW  table write address
wr_data  in  32  note word: [15:0] pitch, [19:16] voice, [25:20] on_ticks, [31:26] off_ticks
start  in  1  begin playback at index 0
stop  in  1  abort playback
loop  in  1  restart at index 0 on end of song
busy  out  1  high while not IDLE
note_index  out  ADDRW  index of current or last loaded note
note_strobe  out  1  one-cycle pulse when a note loads
pitch_increment  out  16  to voice
voice_select  out  4  to voice
gate  out  1  to voice

Behaviour:
- Single clock, sample_clock. rst is synchronous and active-high.
- On reset: all outputs are 0, state is IDLE, prescaler and tick counter are 0. Table contents are not reset.
- Table:
  - Synchronous write, synchronous read.
  - Read-before-write: a write to the address being read in the same cycle returns the old word.
  - Writes are accepted in every state.
- End marker: a note word equal to 32'h0.
- States: IDLE, FETCH, LOAD, ON, OFF.
- IDLE:
  - gate=0.
  - start=1 -> FETCH with index=0.
- FETCH: present index to the table; next state is LOAD. Takes 1 cycle.
- LOAD (the word is valid in this cycle):
  - End marker, or index wrapped past NOTES-1: end of song.
    - loop=1 and the current index is not 0 -> index=0, go to FETCH.
    - Otherwise -> IDLE.
    - An end marker at index 0 always goes to IDLE (empty song).
  - Otherwise:
    - Register pitch and voice into the outputs.
    - note_index=index; note_strobe=1 for this cycle.
    - on_ticks!=0 -> gate=1, go to ON.
    - Else off_ticks!=0 -> go to OFF.
    - Else (both 0) -> index+1, go to FETCH.
- ON / OFF:
  - The prescaler counts 0..TICKDIV-1. A tick fires when it reaches TICKDIV-1.
  - Both the prescaler and the tick counter clear on phase entry.
  - ON lasts exactly on_ticks*TICKDIV cycles.
  - At the end of ON: gate=0, then go to OFF if off_ticks!=0, else to FETCH with index+1.
  - OFF lasts exactly off_ticks*TICKDIV cycles, then goes to FETCH with index+1.
- Per-note overhead: 2 cycles (FETCH, LOAD). gate falls between notes only if off_ticks>0 or across that overhead.
- gate is registered. It is high exactly for the ON-state cycles, plus 1 cycle of register latency (rises the cycle after LOAD).
- Index increments modulo NOTES. Wrap from NOTES-1 to 0 is handled as end of song.
- stop:
  - Any state -> IDLE next cycle, with gate=0.
  - pitch_increment and voice_select hold their values.
  - stop has priority over start in the same cycle.
- start while busy: ignored.
- rst mid-playback: reset values apply next cycle; the table is retained.
- busy=1 in FETCH, LOAD, ON and OFF.

Test Plan:
1. TICKDIV=4. Write {off=2, on=3, voice=1, pitch=16'h0100} at index 0 and 0 at index 1; pulse start.
   -> note_strobe at cycle 2; pitch=0x0100, voice=1; gate high 12 cycles; low 8 cycles; busy drops 2 cycles later (FETCH, LOAD of the marker).
2. Same table with loop=1.
   -> note_strobe repeats every 24 cycles; note_index stays 0; gate pattern is periodic.
3. Fill all 16 entries with on=1, off=0, pitch=k.
   -> pitch steps 0..15; gate stays high except for a 2-cycle dip between notes; wrap ends the song with loop=0.
4. Assert stop in the middle of the ON phase of note 1.
   -> gate=0 and busy=0 next cycle; pitch holds; a subsequent start replays from index 0.
5. Table all zeros with loop=1; start.
   -> busy high for exactly 2 cycles, then IDLE; note_strobe never fires.
6. Word with on=0, off=0, pitch=0x0200 at index 0, followed by a normal note at index 1.
   -> two note_strobes, 2 cycles apart; gate never rises for index 0. Also: start and stop in the same cycle -> stays IDLE.
